// File: rtl/lsu_pkg.sv
// Shared types for the memory stage.
//   memory_signals    : bundle handed over by the execute unit
//   writeback_signals : MEM/WB register contents
//   lsu_state_e       : LSU bus-sequencing state
//   F3_*              : funct3 access-width codes
//   is_misaligned()   : alignment check for a given width and low address bits
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        mm_re;
    logic        mm_we;
    logic [31:0] mm_addr;
    logic [31:0] data;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
  } memory_signals;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] data;
    logic        valid;
  } writeback_signals;

  typedef enum logic {
    S_IDLE,
    S_BUS
  } lsu_state_e;

  // Undefined widths behave as words, so they need full word alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    case (f3)
      F3_LB, F3_LBU: r = 1'b0;
      F3_LH, F3_LHU: r = lo[0];
      default:       r = (lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   st_funct3_i/st_addr_i/st_data_i : store width, low address bits, raw store data
//   be_o/wdata_o                    : byte enables and lane-replicated write data
//   ld_funct3_i/ld_addr_i/rdata_i   : captured load width, low address bits, bus data
//   ld_data_o                       : selected lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (st_funct3_i)
      F3_LB, F3_LBU: begin
        be_o    = 4'b0001 << st_addr_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      F3_LH, F3_LHU: begin
        be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata_i[7:0];
    case (ld_addr_i)
      2'd0: ld_byte = rdata_i[7:0];
      2'd1: ld_byte = rdata_i[15:8];
      2'd2: ld_byte = rdata_i[23:16];
      2'd3: ld_byte = rdata_i[31:24];
      default: ;
    endcase
    ld_half = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ld_data_o = rdata_i;
    case (ld_funct3_i)
      F3_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LBU: ld_data_o = {24'h0, ld_byte};
      F3_LHU: ld_data_o = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory stage: executes loads/stores over a single-outstanding req/ack data
// bus and holds the MEM/WB register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   valid_in, signals_in  : instruction from execute
//   stall                 : upstream must hold its outputs
//   wb_valid/rd_addr/data : writeback bundle (rd 0 = no register write)
//   misaligned, bus_err   : one-cycle fault pulses
//   dbus_*                : data bus master side
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  memory_signals     signals_in,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              misaligned,
  output logic              bus_err,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [XLEN-1:0]   dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [XLEN-1:0]   dbus_wdata,
  input  logic [XLEN-1:0]   dbus_rdata,
  input  logic              dbus_ack
);

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [31:0]      cnt_q;
  writeback_signals wb_q;
  logic             misaligned_q, bus_err_q;
  logic             dbus_req_q, dbus_we_q;
  logic [31:0]      dbus_addr_q, dbus_wdata_q;
  logic [3:0]       dbus_be_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [4:0]       rd_q;

  logic        is_mem, mis, start, timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign is_mem  = signals_in.mm_re | signals_in.mm_we;
  assign mis     = is_misaligned(signals_in.funct3, signals_in.mm_addr[1:0]);
  assign start   = (state_q == S_IDLE) && valid_in && is_mem && !mis;
  // cnt_q counts completed BUS cycles, so the last permitted cycle is TIMEOUT-1.
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  lsu_align u_align (
    .st_funct3_i (signals_in.funct3),
    .st_addr_i   (signals_in.mm_addr[1:0]),
    .st_data_i   (signals_in.store_data),
    .be_o        (st_be),
    .wdata_o     (st_wdata),
    .ld_funct3_i (f3_q),
    .ld_addr_i   (lo_q),
    .rdata_i     (dbus_rdata),
    .ld_data_o   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_BUS;
      S_BUS:  if (dbus_ack || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = (state_q == S_BUS) || start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      wb_q         <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= '0;
      dbus_wdata_q <= '0;
      f3_q         <= '0;
      lo_q         <= '0;
      rd_q         <= '0;
    end else begin
      wb_q.valid   <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            if (!is_mem) begin
              wb_q.valid   <= 1'b1;
              wb_q.rd_addr <= signals_in.rd_addr;
              wb_q.data    <= signals_in.data;
            end else if (mis) begin
              misaligned_q <= 1'b1;
              wb_q.valid   <= 1'b1;
              wb_q.rd_addr <= '0;
            end else begin
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= signals_in.mm_we;
              dbus_addr_q  <= {signals_in.mm_addr[31:2], 2'b00};
              dbus_be_q    <= st_be;
              dbus_wdata_q <= st_wdata;
              f3_q         <= signals_in.funct3;
              lo_q         <= signals_in.mm_addr[1:0];
              rd_q         <= signals_in.rd_addr;
              cnt_q        <= '0;
            end
          end
        end
        S_BUS: begin
          if (dbus_ack) begin
            dbus_req_q <= 1'b0;
            wb_q.valid <= 1'b1;
            if (dbus_we_q) begin
              wb_q.rd_addr <= '0;
            end else begin
              wb_q.rd_addr <= rd_q;
              wb_q.data    <= ld_data;
            end
          end else if (timeout) begin
            dbus_req_q   <= 1'b0;
            bus_err_q    <= 1'b1;
            wb_q.valid   <= 1'b1;
            wb_q.rd_addr <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_valid   = wb_q.valid;
  assign wb_rd_addr = wb_q.rd_addr;
  assign wb_data    = wb_q.data;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_be    = dbus_be_q;
  assign dbus_wdata = dbus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (TIMEOUT_CYCLES = 4).
module tb_lsu;
  import lsu_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  memory_signals signals_in = '0;
  logic          stall, wb_valid, misaligned, bus_err;
  logic [4:0]    wb_rd_addr;
  logic [31:0]   wb_data;
  logic          dbus_req, dbus_we, dbus_ack = 1'b0;
  logic [31:0]   dbus_addr, dbus_wdata, dbus_rdata = '0;
  logic [3:0]    dbus_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .signals_in(signals_in),
    .stall(stall), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .misaligned(misaligned), .bus_err(bus_err), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic re, input logic we,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] sd, input logic [4:0] rd);
    valid_in              = 1'b1;
    signals_in.funct3     = f3;
    signals_in.mm_re      = re;
    signals_in.mm_we      = we;
    signals_in.mm_addr    = addr;
    signals_in.data       = data;
    signals_in.store_data = sd;
    signals_in.rd_addr    = rd;
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({stall, wb_valid, wb_rd_addr, wb_data, misaligned, bus_err, dbus_req, dbus_we,
         dbus_addr, dbus_be, dbus_wdata} !== '0) begin
      $display("FAIL reset_outputs: got nonzero (wb_data=%h dbus_req=%b stall=%b) want all 0",
               wb_data, dbus_req, stall);
      miscompares++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(F3_LW, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 5'd5);
    vectors++;
    if (stall !== 1'b0) begin
      $display("FAIL alu_stall: got %b want 0", stall); miscompares++;
    end
    tick();
    vectors++;
    if ({wb_valid, wb_rd_addr, wb_data, stall} !== {1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
      $display("FAIL alu_wb: got v=%b rd=%0d d=%h stall=%b want v=1 rd=5 d=12345678 stall=0",
               wb_valid, wb_rd_addr, wb_data, stall);
      miscompares++;
    end
    valid_in = 1'b0;
    tick();
    vectors++;
    if ({wb_valid, wb_rd_addr, wb_data} !== {1'b0, 5'd5, 32'h1234_5678}) begin
      $display("FAIL idle_hold: got v=%b rd=%0d d=%h want v=0 rd=5 d=12345678",
               wb_valid, wb_rd_addr, wb_data);
      miscompares++;
    end
  endtask

  task automatic test_store_byte();
    int stalls = 0;
    drive(F3_LB, 1'b0, 1'b1, 32'h0000_1003, 32'h0, 32'h0000_00AB, 5'd0);
    if (stall) stalls++;
    tick();
    vectors++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata} !==
        {1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB}) begin
      $display("FAIL sb_bus: got req=%b we=%b a=%h be=%b wd=%h want 1 1 00001000 1000 abababab",
               dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata);
      miscompares++;
    end
    if (stall) stalls++;
    tick();
    if (stall) stalls++;
    tick();
    if (stall) stalls++;
    vectors++;
    if ({dbus_req, dbus_addr, dbus_be, dbus_wdata} !== {1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB}) begin
      $display("FAIL sb_hold: got req=%b a=%h be=%b wd=%h", dbus_req, dbus_addr, dbus_be, dbus_wdata);
      miscompares++;
    end
    dbus_ack = 1'b1;
    valid_in = 1'b0;
    tick();
    dbus_ack = 1'b0;
    if (stall) stalls++;
    vectors++;
    if ({wb_valid, wb_rd_addr, dbus_req} !== {1'b1, 5'd0, 1'b0}) begin
      $display("FAIL sb_retire: got v=%b rd=%0d req=%b want v=1 rd=0 req=0",
               wb_valid, wb_rd_addr, dbus_req);
      miscompares++;
    end
    vectors++;
    if (stalls !== 4) begin
      $display("FAIL sb_stall_cycles: got %0d want 4", stalls); miscompares++;
    end
    tick();
    vectors++;
    if (wb_valid !== 1'b0) begin
      $display("FAIL sb_wb_pulse: got %b want 0", wb_valid); miscompares++;
    end
  endtask

  task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    drive(f3, 1'b1, 1'b0, addr, 32'h0, 32'h0, rd);
    tick();
    vectors++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be} !== {1'b1, 1'b0, {addr[31:2], 2'b00}, exp_be}) begin
      $display("FAIL %s_bus: got req=%b we=%b a=%h be=%b want be=%b", nm,
               dbus_req, dbus_we, dbus_addr, dbus_be, exp_be);
      miscompares++;
    end
    valid_in   = 1'b0;
    dbus_ack   = 1'b1;
    dbus_rdata = rdata;
    tick();
    dbus_ack   = 1'b0;
    vectors++;
    if ({wb_valid, wb_rd_addr, wb_data} !== {1'b1, rd, exp_data}) begin
      $display("FAIL %s_wb: got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h", nm,
               wb_valid, wb_rd_addr, wb_data, rd, exp_data);
      miscompares++;
    end
  endtask

  task automatic test_loads();
    do_load("lh",  F3_LH,  32'h0000_2002, 5'd7, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", F3_LHU, 32'h0000_2002, 5'd7, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    do_load("lb",  F3_LB,  32'h0000_4001, 5'd8, 32'h0000_9C00, 4'b0010, 32'hFFFF_FF9C);
    do_load("lbu", F3_LBU, 32'h0000_4003, 5'd8, 32'hF000_0000, 4'b1000, 32'h0000_00F0);
  endtask

  task automatic test_misaligned();
    drive(F3_LW, 1'b1, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 5'd9);
    vectors++;
    if (stall !== 1'b0) begin
      $display("FAIL mis_stall: got %b want 0", stall); miscompares++;
    end
    tick();
    vectors++;
    if ({misaligned, wb_valid, wb_rd_addr, dbus_req} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
      $display("FAIL mis_lw: got mis=%b v=%b rd=%0d req=%b want 1 1 0 0",
               misaligned, wb_valid, wb_rd_addr, dbus_req);
      miscompares++;
    end
    drive(F3_LHU, 1'b1, 1'b0, 32'h0000_3003, 32'h0, 32'h0, 5'd9);
    tick();
    vectors++;
    if ({misaligned, wb_valid, wb_rd_addr, dbus_req} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
      $display("FAIL mis_lhu: got mis=%b v=%b rd=%0d req=%b want 1 1 0 0",
               misaligned, wb_valid, wb_rd_addr, dbus_req);
      miscompares++;
    end
    valid_in = 1'b0;
    tick();
    vectors++;
    if ({misaligned, wb_valid} !== 2'b00) begin
      $display("FAIL mis_pulse: got mis=%b v=%b want 0 0", misaligned, wb_valid); miscompares++;
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    drive(F3_LW, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 5'd3);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus_err || !stall || !dbus_req) early++;
      tick();
    end
    if (bus_err || !stall || !dbus_req) early++;
    vectors++;
    if (early !== 0) begin
      $display("FAIL to_early: got %0d bad BUS cycles want 0", early); miscompares++;
    end
    tick();
    vectors++;
    if ({bus_err, wb_valid, wb_rd_addr, stall, dbus_req} !== {1'b1, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      $display("FAIL to_abort: got err=%b v=%b rd=%0d stall=%b req=%b want 1 1 0 0 0",
               bus_err, wb_valid, wb_rd_addr, stall, dbus_req);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus_err !== 1'b0) begin
      $display("FAIL to_pulse: got %b want 0", bus_err); miscompares++;
    end
    // ack lands in the fourth BUS cycle, the same cycle the timeout would fire
    drive(F3_LW, 1'b1, 1'b0, 32'h0000_5004, 32'h0, 32'h0, 5'd4);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hCAFE_F00D;
    tick();
    dbus_ack   = 1'b0;
    vectors++;
    if ({bus_err, wb_valid, wb_rd_addr, wb_data} !== {1'b0, 1'b1, 5'd4, 32'hCAFE_F00D}) begin
      $display("FAIL to_ack_wins: got err=%b v=%b rd=%0d d=%h want 0 1 4 cafef00d",
               bus_err, wb_valid, wb_rd_addr, wb_data);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    drive(F3_LH, 1'b0, 1'b1, 32'h0000_7002, 32'h0, 32'h1234_BEEF, 5'd0);
    tick();
    vectors++;
    if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !== {1'b1, 32'h0000_7000, 4'b1100, 32'hBEEF_BEEF}) begin
      $display("FAIL sh_bus: got we=%b a=%h be=%b wd=%h want 1 00007000 1100 beefbeef",
               dbus_we, dbus_addr, dbus_be, dbus_wdata);
      miscompares++;
    end
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    drive(F3_LW, 1'b0, 1'b1, 32'h0000_7008, 32'h0, 32'h1122_3344, 5'd0);
    tick();
    vectors++;
    if ({dbus_req, dbus_be, dbus_wdata} !== {1'b1, 4'b1111, 32'h1122_3344}) begin
      $display("FAIL sw_bus: got req=%b be=%b wd=%h want 1 1111 11223344",
               dbus_req, dbus_be, dbus_wdata);
      miscompares++;
    end
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    drive(F3_LW, 1'b0, 1'b0, 32'h0, 32'h6666_0006, 32'h0, 5'd6);
    vectors++;
    if ({wb_valid, wb_rd_addr, stall} !== {1'b1, 5'd0, 1'b0}) begin
      $display("FAIL sw_retire: got v=%b rd=%0d stall=%b want 1 0 0", wb_valid, wb_rd_addr, stall);
      miscompares++;
    end
    tick();
    vectors++;
    if ({wb_valid, wb_rd_addr, wb_data} !== {1'b1, 5'd6, 32'h6666_0006}) begin
      $display("FAIL b2b_alu: got v=%b rd=%0d d=%h want 1 6 66660006",
               wb_valid, wb_rd_addr, wb_data);
      miscompares++;
    end
    valid_in = 1'b0;
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    vectors++;
    if ({wb_valid, dbus_req, stall} !== 3'b000) begin
      $display("FAIL idle_ack_ignored: got v=%b req=%b stall=%b want 0 0 0",
               wb_valid, dbus_req, stall);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_bus();
    drive(F3_LW, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 32'h0, 5'd10);
    tick();
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({stall, wb_valid, wb_rd_addr, wb_data, misaligned, bus_err, dbus_req, dbus_we,
         dbus_addr, dbus_be, dbus_wdata} !== '0) begin
      $display("FAIL rst_mid_bus: got req=%b stall=%b a=%h wd=%h want all 0",
               dbus_req, stall, dbus_addr, dbus_wdata);
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    vectors++;
    if (wb_valid !== 1'b0) begin
      $display("FAIL rst_no_wb: got %b want 0", wb_valid); miscompares++;
    end
    drive(F3_LW, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd12);
    tick();
    valid_in = 1'b0;
    vectors++;
    if ({wb_valid, wb_rd_addr, wb_data} !== {1'b1, 5'd12, 32'hDEAD_BEEF}) begin
      $display("FAIL rst_then_alu: got v=%b rd=%0d d=%h want 1 12 deadbeef",
               wb_valid, wb_rd_addr, wb_data);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Memory stage of the core pipeline; sits directly downstream of the integer execute unit and consumes its `memory_signals` bundle.
- Performs loads and stores over a single-outstanding request/acknowledge data bus, including byte-lane steering, sign/zero extension, a misalignment check and an ack timeout.
- Holds the MEM/WB pipeline register and stalls upstream stages while a bus access is in flight.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 255, cycles to wait for `dbus_ack` before aborting; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  `signals_in` holds a live instruction
- signals_in  in  memory_signals  funct3, mm_re, mm_we, mm_addr, data, store_data, rd_addr
- stall  out  1  upstream must hold `signals_in` and `valid_in` stable
- wb_valid  out  1  writeback bundle valid this cycle
- wb_rd_addr  out  5  destination register; 0 means no write
- wb_data  out  XLEN  result to the register file
- misaligned  out  1  one-cycle pulse on an unaligned access
- bus_err  out  1  one-cycle pulse on an ack timeout
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  XLEN  word-aligned address (bits [1:0] = 0)
- dbus_be  out  4  byte enables
- dbus_wdata  out  XLEN  lane-steered store data
- dbus_rdata  in  XLEN  read data, valid while `dbus_ack` = 1
- dbus_ack  in  1  access complete, single-cycle pulse

Behaviour:
- Interface: single clock `clk`; asynchronous active-low reset `rst_n`.
- Reset (async):
  - State = IDLE, counter = 0.
  - All outputs 0: `stall`, `wb_valid`, `wb_rd_addr`, `wb_data`, `misaligned`, `bus_err`, and every `dbus_*` output.
- States: IDLE, BUS.
- IDLE, non-memory instruction (`valid_in`, `mm_re` = `mm_we` = 0):
  - Next edge registers `wb_valid` = 1, `wb_rd_addr` = `rd_addr`, `wb_data` = `signals_in.data`.
  - One-cycle latency, no stall.
- IDLE, memory instruction:
  - Misaligned means: halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - If misaligned: next edge pulses `misaligned`, `wb_valid` = 1, `wb_rd_addr` = 0; no bus access.
  - Otherwise: next edge goes to BUS and registers the request:
    - `dbus_req` = 1, `dbus_we` = `mm_we`, `dbus_addr` = `{addr[31:2], 2'b00}`, `dbus_be`, `dbus_wdata`.
    - Captures `funct3`, `addr[1:0]` and `rd_addr` internally.
    - `wb_valid` = 0.
  - `stall` is combinational: asserted in IDLE while an aligned memory instruction is presented, and at all times in BUS.
- Byte enables and store data by funct3:
  - Byte (000/100): `be = 1 << addr[1:0]`; store byte replicated ×4.
  - Half (001/101): `be = 0011` or `1100` per `addr[1]`; store half replicated ×2.
  - Word (010): `be = 1111`.
  - Undefined funct3 is treated as word.
- BUS:
  - `dbus_*` outputs held stable until ack; counter increments each cycle.
  - On `dbus_ack`: next edge returns to IDLE, `dbus_req` = 0, `wb_valid` = 1.
    - Load: `wb_data` = selected lane, sign-extended (000/001) or zero-extended (100/101); `wb_rd_addr` = captured rd.
    - Store: `wb_rd_addr` = 0.
  - Timeout: counter reaches TIMEOUT_CYCLES without ack → return to IDLE, pulse `bus_err`, `wb_valid` = 1 with `wb_rd_addr` = 0.
  - Ack and timeout in the same cycle: ack wins.
  - Counter is cleared on entry to BUS.
- `wb_valid` is high for exactly one cycle per retired instruction.
- `valid_in` = 0 in IDLE: `wb_valid` = 0 next cycle and `wb_*` hold their values.
- `dbus_ack` arriving while in IDLE is ignored.
- Reset asserted mid-BUS: request dropped immediately; no writeback occurs.

Decomposition:
- `pipeline` package:
  - Add `store_data` to `memory_signals`.
  - Add `writeback_signals` (rd_addr, data, valid).
  - Add localparams for the funct3 width codes (LB, LH, LW, LBU, LHU).
- One sub-module, `lsu_align`, purely combinational:
  - Store lane steering and `be` generation.
  - Load lane select and sign/zero extension.

Test Plan:
- ALU op, `rd` = 5, `data` = 0x1234_5678 → next cycle `wb_valid` = 1, `wb_rd_addr` = 5, `wb_data` = 0x1234_5678; `stall` never asserted.
- SB at 0x1003, `store_data` = 0xAB, ack after 3 cycles:
  - `dbus_addr` = 0x1000, `be` = 1000, `wdata` = 0xABAB_ABAB.
  - `stall` high for 4 cycles, `wb_rd_addr` = 0.
- LH at 0x2002, `rdata` = 0x8001_0000 → `be` = 1100, `wb_data` = 0xFFFF_8001; LHU at the same address → 0x0000_8001.
- LW at 0x3001 → `misaligned` pulses, `dbus_req` stays 0, `wb_rd_addr` = 0.
- LW with no ack, TIMEOUT_CYCLES = 4 → `bus_err` pulses after 4 BUS cycles and `stall` drops; with ack and timeout in the same cycle → normal load result.
- `rst_n` low during BUS → all outputs 0 asynchronously; after release, the next ALU op writes back normally.
